// File: rtl/ring_sequence_checker.sv
// ring_sequence_checker: locks onto a rotating one-hot ring pattern, reports the hot-bit position,
// pulses frame on MSB-hot words and counts sequence errors.
module ring_sequence_checker #(
  parameter int WIDTH = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_LIMIT = 2,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic             locked,
  output logic [POS_W-1:0] pos,
  output logic             frame,
  output logic             err,
  output logic [15:0]      err_count
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(ERR_LIMIT + 1);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t state;
  logic [WIDTH-1:0] expected;
  logic [GW-1:0] good_cnt;
  logic [MW-1:0] miss_cnt;
  logic hot;
  assign hot = $onehot(din);
  function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] x);
    rot = {x[0], x[WIDTH-1:1]};
  endfunction
  function automatic logic [POS_W-1:0] idx(input logic [WIDTH-1:0] x);
    idx = '0;
    for (int i = 0; i < WIDTH; i++) if (x[i]) idx = idx | POS_W'(i);
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      expected  <= '0;
      good_cnt  <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      pos       <= '0;
      frame     <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      frame <= 1'b0;
      err   <= 1'b0;
      if (en) begin
        case (state)
          HUNT: if (hot) begin
            expected <= rot(din);
            good_cnt <= GW'(1);
            state    <= VERIFY;
          end
          VERIFY: if (din == expected) begin
            expected <= rot(din);
            good_cnt <= good_cnt + GW'(1);
            if (good_cnt == GW'(LOCK_COUNT - 1)) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              miss_cnt <= '0;
              pos      <= idx(din);
              frame    <= din[WIDTH-1];
            end
          end else if (hot) begin
            good_cnt <= GW'(1);
            expected <= rot(din);
          end else begin
            good_cnt <= '0;
            state    <= HUNT;
          end
          LOCKED: if (din == expected) begin
            pos      <= idx(din);
            miss_cnt <= '0;
            expected <= rot(din);
            frame    <= din[WIDTH-1];
          end else begin
            // flywheel: keep rotating the local copy rather than trusting din
            err       <= 1'b1;
            err_count <= (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
            miss_cnt  <= miss_cnt + MW'(1);
            expected  <= rot(expected);
            if (miss_cnt == MW'(ERR_LIMIT - 1)) begin
              state    <= HUNT;
              locked   <= 1'b0;
              pos      <= '0;
              good_cnt <= '0;
            end else begin
              pos <= idx(expected);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ring_sequence_checker.sv
// tb_ring_sequence_checker: table-driven directed vectors, async reset check, and randomized
// stimulus compared against a position-arithmetic reference model.
module tb_ring_sequence_checker;
  localparam int W = 4;
  localparam int LC = 3;
  localparam int EL = 2;
  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [W-1:0] din;
  logic locked;
  logic [1:0] pos;
  logic frame;
  logic err;
  logic [15:0] err_count;
  int n_chk = 0;
  int n_fail = 0;
  ring_sequence_checker #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_LIMIT(EL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .locked(locked),
    .pos(pos), .frame(frame), .err(err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic e;
    logic [W-1:0] d;
    logic l;
    int p;
    logic f;
    logic er;
    int ec;
  } vec_t;
  vec_t tv[$];
  task automatic v(input logic e, input logic [W-1:0] d, input logic l, input int p,
                   input logic f, input logic er, input int ec);
    vec_t t;
    t.e = e; t.d = d; t.l = l; t.p = p; t.f = f; t.er = er; t.ec = ec;
    tv.push_back(t);
  endtask
  task automatic chk(input string n, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(input logic e, input logic [W-1:0] d);
    en = e;
    din = d;
    @(posedge clk);
    #1;
  endtask
  // reference model: tracks hot positions as integers, rotation = position minus one mod W
  int m_mode, m_exp, m_run, m_miss, m_errs, m_pos;
  logic m_frame, m_err;
  task automatic model_reset();
    m_mode = 0; m_exp = -1; m_run = 0; m_miss = 0; m_errs = 0; m_pos = 0;
    m_frame = 0; m_err = 0;
  endtask
  task automatic model_step(input logic e, input logic [W-1:0] d);
    int p;
    m_frame = 0;
    m_err = 0;
    if (!e) return;
    p = ($countones(d) == 1) ? $clog2(d) : -1;
    if (m_mode == 0) begin
      if (p >= 0) begin m_exp = (p + W - 1) % W; m_run = 1; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (p >= 0 && p == m_exp) begin
        m_run++;
        m_exp = (p + W - 1) % W;
        if (m_run == LC) begin m_mode = 2; m_miss = 0; m_pos = p; m_frame = (p == W - 1); end
      end else if (p >= 0) begin
        m_run = 1; m_exp = (p + W - 1) % W;
      end else begin
        m_run = 0; m_mode = 0;
      end
    end else begin
      if (p >= 0 && p == m_exp) begin
        m_pos = p; m_miss = 0; m_frame = (p == W - 1); m_exp = (p + W - 1) % W;
      end else begin
        m_err = 1;
        if (m_errs < 65535) m_errs++;
        m_miss++;
        if (m_miss == EL) begin m_mode = 0; m_pos = 0; m_run = 0; end
        else m_pos = m_exp;
        m_exp = (m_exp + W - 1) % W;
      end
    end
  endtask
  initial begin
    logic [W-1:0] d;
    logic e;
    int gp, r;
    rst_n = 1'b0; en = 1'b0; din = '0;
    #8;
    chk("rst_locked", locked, 0);
    chk("rst_pos", pos, 0);
    chk("rst_errcnt", err_count, 0);
    #4 rst_n = 1'b1;
    // lock, flywheel, drop, relock, en hold, drop again, noisy hunt, relock
    v(1,4'b1000,0,0,0,0,0); v(1,4'b0100,0,0,0,0,0); v(1,4'b0010,1,1,0,0,0);
    v(1,4'b0001,1,0,0,0,0); v(1,4'b1000,1,3,1,0,0); v(1,4'b0100,1,2,0,0,0);
    v(1,4'b0010,1,1,0,0,0); v(1,4'b0110,1,0,0,1,1); v(1,4'b1000,1,3,1,0,1);
    v(1,4'b0000,1,2,0,1,2); v(1,4'b1111,0,0,0,1,3); v(1,4'b0010,0,0,0,0,3);
    v(1,4'b0001,0,0,0,0,3); v(1,4'b1000,1,3,1,0,3); v(0,4'b1010,1,3,0,0,3);
    v(0,4'b1010,1,3,0,0,3); v(0,4'b1010,1,3,0,0,3); v(1,4'b0100,1,2,0,0,3);
    v(1,4'b0010,1,1,0,0,3); v(1,4'b0000,1,0,0,1,4); v(1,4'b0000,0,0,0,1,5);
    v(1,4'b0000,0,0,0,0,5); v(1,4'b1100,0,0,0,0,5); v(1,4'b0100,0,0,0,0,5);
    v(1,4'b0001,0,0,0,0,5); v(1,4'b1000,0,0,0,0,5); v(1,4'b0100,1,2,0,0,5);
    v(1,4'b0010,1,1,0,0,5);
    foreach (tv[i]) begin
      cyc(tv[i].e, tv[i].d);
      chk($sformatf("v%0d_locked", i), locked, tv[i].l);
      chk($sformatf("v%0d_pos", i), pos, tv[i].p);
      chk($sformatf("v%0d_frame", i), frame, tv[i].f);
      chk($sformatf("v%0d_err", i), err, tv[i].er);
      chk($sformatf("v%0d_errcnt", i), err_count, tv[i].ec);
    end
    // asynchronous reset mid-cycle while locked
    #2 rst_n = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_pos", pos, 0);
    chk("arst_errcnt", err_count, 0);
    #1 rst_n = 1'b1;
    cyc(1, 4'b0001);
    chk("arst_hunt_locked", locked, 0);
    cyc(1, 4'b1000);
    cyc(1, 4'b0100);
    chk("arst_relock", locked, 1);
    chk("arst_relock_pos", pos, 2);
    // randomized run against the model
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    gp = 3;
    for (int k = 0; k < 600; k++) begin
      e = ($urandom % 8) != 0;
      r = $urandom % 10;
      if (r < 7) d = 4'b0001 << gp;
      else if (r == 7) begin gp = $urandom % W; d = 4'b0001 << gp; end
      else d = W'($urandom % 16);
      cyc(e, d);
      if (e && r < 8) gp = (gp + W - 1) % W;
      model_step(e, d);
      chk("rnd_locked", locked, (m_mode == 2) ? 1 : 0);
      chk("rnd_pos", pos, m_pos);
      chk("rnd_frame", frame, m_frame);
      chk("rnd_err", err, m_err);
      chk("rnd_errcnt", err_count, m_errs);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
